// File: rtl/seg_display_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seg_display_ctrl_pkg
// Shared definitions for the multiplexed 7-segment display controller:
// FSM state encoding, active-low segment codes (bit 6 = a .. bit 0 = g),
// active-low anode patterns and the BCD conversion iteration count.
// ---------------------------------------------------------------------------
package seg_display_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        CONVERT = 2'd2,
        SHOW    = 2'd3
    } state_t;

    // One shift-add-3 iteration per input bit of the 13-bit source values.
    localparam int BCD_ITER = 13;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_THOU = 4'b0111;
    localparam logic [3:0] AN_HUND = 4'b1011;
    localparam logic [3:0] AN_TENS = 4'b1101;
    localparam logic [3:0] AN_ONES = 4'b1110;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Non-decimal nibbles fall back to "0" rather than garbage segments.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_0;
        endcase
    endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg_display_ctrl_if
// Bundles the source request inputs and display outputs of seg_display_ctrl.
//   src_valid[3:0]   per-source request
//   src_value[51:0]  four 13-bit values, source k at [13k+12:13k]
//   manual, sel[1:0] manual mode enable and source index
//   anode[3:0]       active-low digit enables (bit 3 = thousands)
//   led_out[6:0]     active-low segments a..g (bit 6 = a)
//   active_src[1:0]  source currently displayed
//   busy             BCD conversion in progress
// master drives the requests, slave is the controller.
// ---------------------------------------------------------------------------
interface seg_display_ctrl_if;
    logic [3:0]  src_valid;
    logic [51:0] src_value;
    logic        manual;
    logic [1:0]  sel;
    logic [3:0]  anode;
    logic [6:0]  led_out;
    logic [1:0]  active_src;
    logic        busy;

    modport master (
        output src_valid, src_value, manual, sel,
        input  anode, led_out, active_src, busy
    );

    modport slave (
        input  src_valid, src_value, manual, sel,
        output anode, led_out, active_src, busy
    );
endinterface

// File: rtl/seg_display_ctrl_conv.sv
// ---------------------------------------------------------------------------
// bcd_seq_conv
// Sequential shift-add-3 (double dabble) binary to BCD converter.
//   clk, rst    clock, synchronous active-high reset
//   start       one-cycle pulse; bin is captured on this edge
//   bin[12:0]   binary value to convert
//   done        high during the cycle whose edge performs the last iteration
//   bcd[15:0]   four BCD digits, valid from the cycle after done
// One iteration per cycle, BCD_ITER iterations after the start edge.
// ---------------------------------------------------------------------------
module bcd_seq_conv
    import seg_display_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [12:0] bin,
    output logic        done,
    output logic [15:0] bcd
);

    localparam logic [3:0] LAST_ITER = 4'(BCD_ITER - 1);

    logic [12:0] shreg;
    logic [3:0]  iter_cnt;
    logic        running;

    function automatic logic [15:0] add3_all(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign done = running && (iter_cnt == LAST_ITER);

    always_ff @(posedge clk) begin
        if (rst) begin
            running  <= 1'b0;
            iter_cnt <= '0;
        end else if (start) begin
            running  <= 1'b1;
            iter_cnt <= '0;
        end else if (running) begin
            iter_cnt <= iter_cnt + 4'd1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

    // Data path: adjust digits, then shift the next binary MSB in.
    always_ff @(posedge clk) begin
        if (start) begin
            shreg <= bin;
            bcd   <= '0;
        end else if (running) begin
            {bcd, shreg} <= {add3_all(bcd), shreg} << 1;
        end
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// ---------------------------------------------------------------------------
// seg_display_ctrl
// Round-robin (or manually selected) display of four 13-bit sources on a
// 4-digit multiplexed 7-segment display.
//   clk, rst  clock, synchronous active-high reset
//   bus       seg_display_ctrl_if.slave (requests in, display/status out)
// Parameters:
//   DWELL_CYCLES  cycles each source stays in SHOW
//   REFRESH_BITS  scan counter width; its two MSBs select the digit
// A new value reaches the display buffer 15 cycles after LOAD entry:
// 1 LOAD + 13 CONVERT + 1 SHOW cycle in which the finished result is latched.
// ---------------------------------------------------------------------------
module seg_display_ctrl
    import seg_display_ctrl_pkg::*;
#(
    parameter int DWELL_CYCLES = 100000000,
    parameter int REFRESH_BITS = 20
) (
    input logic              clk,
    input logic              rst,
    seg_display_ctrl_if.slave bus
);

    localparam int              DW_W       = $clog2(DWELL_CYCLES + 1);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [DW_W-1:0]         dwell_cnt;
    logic [REFRESH_BITS-1:0] scan_cnt;
    logic [1:0]              rr_ptr, active_src_q, sel_q;
    logic                    manual_q;
    logic [15:0]             disp_buf;
    logic                    buf_vld;

    logic [1:0]  rr_pick, load_src, digit_sel;
    logic        rr_any, load_req, mode_changed;
    logic        conv_start, conv_done;
    logic [15:0] conv_bcd;
    logic [3:0]  an_sel, digit;
    logic        blank;

    bcd_seq_conv u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (bus.src_value[13*active_src_q +: 13]),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Round robin: scan from far to near so the closest source after
    // rr_ptr wins; offset 4 wraps back to rr_ptr itself (single source).
    always_comb begin
        rr_pick = rr_ptr;
        rr_any  = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            if (bus.src_valid[rr_ptr + 2'(i)]) begin
                rr_pick = rr_ptr + 2'(i);
                rr_any  = 1'b1;
            end
        end
    end

    assign load_req     = bus.manual | rr_any;
    assign load_src     = bus.manual ? bus.sel : rr_pick;
    assign mode_changed = (bus.manual != manual_q) || (bus.manual && (bus.sel != sel_q));

    always_comb begin
        state_d    = state_q;
        conv_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_req) state_d = LOAD;
            end
            LOAD: begin
                conv_start = 1'b1;
                state_d    = CONVERT;
            end
            CONVERT: begin
                if (conv_done) state_d = SHOW;
            end
            SHOW: begin
                if (mode_changed || (dwell_cnt == DWELL_LAST)) begin
                    state_d = load_req ? LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dwell_cnt    <= '0;
            scan_cnt     <= '0;
            rr_ptr       <= 2'd3;
            active_src_q <= 2'd0;
            manual_q     <= 1'b0;
            sel_q        <= 2'd0;
            disp_buf     <= '0;
            buf_vld      <= 1'b0;
        end else begin
            state_q  <= state_d;
            scan_cnt <= scan_cnt + 1'b1;
            dwell_cnt <= (state_q == SHOW && state_d == SHOW) ? dwell_cnt + 1'b1 : '0;
            // LOAD is only ever entered from IDLE or SHOW, so this is LOAD entry.
            if (state_d == LOAD) begin
                active_src_q <= load_src;
                rr_ptr       <= load_src;
                manual_q     <= bus.manual;
                sel_q        <= bus.sel;
            end
            // First SHOW cycle: the converter result has just settled.
            if (state_q == SHOW && dwell_cnt == '0) begin
                disp_buf <= conv_bcd;
                buf_vld  <= 1'b1;
            end
        end
    end

    assign digit_sel = scan_cnt[REFRESH_BITS-1 -: 2];

    always_comb begin
        an_sel = AN_THOU;
        digit  = disp_buf[15:12];
        case (digit_sel)
            2'd0: begin an_sel = AN_THOU; digit = disp_buf[15:12]; end
            2'd1: begin an_sel = AN_HUND; digit = disp_buf[11:8];  end
            2'd2: begin an_sel = AN_TENS; digit = disp_buf[7:4];   end
            default: begin an_sel = AN_ONES; digit = disp_buf[3:0]; end
        endcase
    end

    assign blank          = (state_q == IDLE) || !buf_vld;
    assign bus.anode      = blank ? AN_OFF : an_sel;
    assign bus.led_out    = blank ? SEG_BLANK : seg_decode(digit);
    assign bus.active_src = active_src_q;
    assign bus.busy       = (state_q == CONVERT);

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 Parameter DWELL_CYCLES, default 100000000, SHALL set the clock cycles each source stays displayed (1 s at 100 MHz).
REQ-002 Parameter REFRESH_BITS, default 20, SHALL set the width of the digit-scan counter; the two MSBs select the digit.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 src_valid  input  4  SHALL be a per-source request; bit k means source k has a value to show.
REQ-006 src_value  input  52  SHALL carry four 13-bit binary values; source k occupies bits [13k+12:13k].
REQ-007 manual  input  1  SHALL select manual mode when high, displaying source sel regardless of src_valid.
REQ-008 sel  input  2  SHALL be the manual source index.
REQ-009 anode  output  4  SHALL be the active-low digit enables; bit 3 is thousands, bit 0 is ones.
REQ-010 led_out  output  7  SHALL be the active-low segments a..g, with bit 6 = a.
REQ-011 active_src  output  2  SHALL be the index of the source currently displayed.
REQ-012 busy  output  1  SHALL be high while a BCD conversion is in progress.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, CONVERT and SHOW.
- IDLE: display blank.
- LOAD: latch the selected 13-bit value (1 cycle).
- CONVERT: run shift-add-3, one bit per cycle, 13 cycles.
- SHOW: latch the four digits into the display buffer on entry, then count dwell.
REQ-014 In IDLE with manual=0, the FSM SHALL go to LOAD when any src_valid bit is set; otherwise it stays in IDLE.
REQ-015 In automatic mode, selection SHALL be round-robin, starting after the last shown source; the first grant after reset is the lowest set bit.
REQ-016 When SHOW dwell reaches DWELL_CYCLES-1, the FSM SHALL go to LOAD with the next valid source, or to IDLE if none are valid.
- A single valid source SHALL be re-converted, refreshing its value.
REQ-017 In manual mode, the FSM SHALL leave IDLE unconditionally.
- A change of sel or manual during SHOW SHALL abort the dwell and go to LOAD next cycle.
- A change during CONVERT SHALL take effect after the current conversion.
REQ-018 Latency SHALL be exactly 15 cycles from LOAD entry to new digits in the display buffer.
REQ-019 busy SHALL be high for exactly 13 cycles, during CONVERT only.
REQ-020 The display buffer SHALL change only on SHOW entry, so no partial conversion is ever visible.
REQ-021 The scan counter SHALL run freely and wrap modulo 2^REFRESH_BITS.
- Digit order SHALL be thousands, hundreds, tens, ones, with anode patterns 0111, 1011, 1101, 1110.
REQ-022 Digits 0-9 SHALL decode to the standard active-low codes; any other value shows "0".
REQ-023 In IDLE the block SHALL drive anode=1111 and led_out=1111111 while the scan counter keeps running.
REQ-024 The maximum input 8191 SHALL display as 8-1-9-1; no overflow is possible at this width.
REQ-025 src_valid dropping during CONVERT SHALL NOT abort; the value SHALL still be shown for the full dwell.

Reset
REQ-026 Reset SHALL be synchronous and active-high, with priority over all other inputs.
- Reset values: state IDLE, anode 1111, led_out 1111111, active_src 0, busy 0, display buffer 0, dwell counter 0, scan counter 0, round-robin pointer 3.
REQ-027 Reset asserted mid-CONVERT or mid-SHOW SHALL discard the conversion and blank the display on the next cycle.

Structure
REQ-028 A shared package SHALL hold:
- the FSM state encoding;
- the 7-segment code table constants;
- the anode pattern constants;
- the BCD_ITER=13 constant.
REQ-029 The shift-add-3 engine SHALL be a separate sub-module, bcd_seq_conv, with a start/done handshake, 13-bit input and 16-bit BCD output; the scan/decode logic and the FSM stay in seg_display_ctrl.

Verification (DWELL_CYCLES=50, REFRESH_BITS=4 in sim)
REQ-030 Reset, then src_valid=0000 for 100 cycles -> anode=1111, led_out=1111111, busy never high.
REQ-031 src_valid=0001, value0=1234 -> busy high 13 cycles; after 15 cycles the digit scan shows 1,2,3,4 (thousands digit: led_out=1001111 with anode=0111).
REQ-032 src_valid=1010, value1=42, value3=8191 -> active_src sequence 1,3,1,3; each SHOW lasts 50 cycles; display reads 0042, then 8191.
REQ-033 manual=1, sel=2, src_valid=0000, value2=7 -> display shows 0007; changing sel to 0 mid-SHOW triggers LOAD on the next cycle.
REQ-034 rst pulsed 1 cycle during CONVERT -> next cycle state is IDLE, display blank, busy=0; the old digits never reappear.
